cv32e40x_rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between the core WB stage and the XIF result channel (offloaded coprocessor results).
- Buffers XIF results in a small FIFO.
- Keeps a scoreboard of destination registers with outstanding XIF writes, and gives the controller read-after-write (RAW) and write-after-write (WAW) stall signals.
- Sits between the WB stage / XIF result interface and the register file, beside the bypass/hazard logic.

---
 rtl/cv32e40x_rf_wb_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cv32e40x_rf_wb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_rf_wb_arbiter.sv
// cv32e40x_rf_wb_arbiter
//   Shares the single register-file write port between the WB stage and the
//   XIF result channel. XIF results are buffered in a small FIFO. A scoreboard
//   of destinations with outstanding XIF writes drives the RAW stall (ID reads)
//   and the WAW issue hazard.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   wb_valid_i/wb_rf_we_i/...    WB stage write request; wb_hold_o stalls WB
//   xif_issue_*                  offload issue handshake, sets scoreboard bits
//   xif_issue_hazard_o           issue rd already pending (WAW)
//   xif_result_*                 XIF result channel (valid/ready)
//   rf_re_id_i/rf_raddr_id_i     ID read ports checked against the scoreboard
//   sb_stall_o                   ID reads a register with a pending XIF write
//   rf_we_o/rf_waddr_o/rf_wdata_o registered RF write port
//
// Build option
//   CV32E40X_XIF_RESULT_BYPASS_EN: a writing result that arrives while the FIFO
//   is empty and WB is not writing goes straight to the RF write register.
module cv32e40x_rf_wb_arbiter #(
  parameter int unsigned RESULT_FIFO_DEPTH      = 2,
  parameter int unsigned STARVE_LIMIT           = 4,
  parameter int unsigned REGFILE_NUM_READ_PORTS = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wb_valid_i,
  input  logic                                   wb_rf_we_i,
  input  logic [4:0]                             wb_rf_waddr_i,
  input  logic [31:0]                            wb_rf_wdata_i,
  output logic                                   wb_hold_o,
  input  logic                                   xif_issue_accept_i,
  input  logic                                   xif_issue_we_i,
  input  logic [4:0]                             xif_issue_rd_i,
  output logic                                   xif_issue_hazard_o,
  input  logic                                   xif_result_valid_i,
  output logic                                   xif_result_ready_o,
  input  logic                                   xif_result_we_i,
  input  logic [4:0]                             xif_result_rd_i,
  input  logic [31:0]                            xif_result_data_i,
  input  logic [REGFILE_NUM_READ_PORTS-1:0]      rf_re_id_i,
  input  logic [REGFILE_NUM_READ_PORTS-1:0][4:0] rf_raddr_id_i,
  output logic                                   sb_stall_o,
  output logic                                   rf_we_o,
  output logic [4:0]                             rf_waddr_o,
  output logic [31:0]                            rf_wdata_o
);

  localparam int unsigned PTR_W = (RESULT_FIFO_DEPTH > 1) ? $clog2(RESULT_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESULT_FIFO_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       fifo_rd_q   [RESULT_FIFO_DEPTH];
  logic [31:0]      fifo_data_q [RESULT_FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [31:0]      pending_q, pending_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  logic fifo_empty, fifo_full;
  logic wb_grant, fifo_grant, byp_grant;
  logic res_write, push;
  logic [31:0] set_vec, clr_vec;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(RESULT_FIFO_DEPTH));

  // Hold is decoded from the registered counter so WB sees it early in the cycle.
  assign wb_hold_o  = (starve_q == STV_W'(STARVE_LIMIT));
  assign wb_grant   = wb_valid_i & wb_rf_we_i & ~wb_hold_o;
  assign fifo_grant = ~wb_grant & ~fifo_empty;

  // Ready is gated by reset so nothing is accepted while reset is asserted.
  // Full is taken before any same-cycle pop: no pass-through at full.
  assign xif_result_ready_o = rst_n & ~fifo_full;
  assign res_write = xif_result_valid_i & xif_result_ready_o & xif_result_we_i &
                     (xif_result_rd_i != 5'd0);

`ifdef CV32E40X_XIF_RESULT_BYPASS_EN
  assign byp_grant = res_write & fifo_empty & ~wb_grant;
`else
  assign byp_grant = 1'b0;
`endif

  assign push = res_write & ~byp_grant;

  assign wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d   = fifo_grant ? rptr_q + 1'b1 : rptr_q;
  assign cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(fifo_grant);
  assign starve_d = (fifo_empty || fifo_grant) ? '0 : starve_q + 1'b1;

  // Scoreboard: set on issue, clear when the result reaches the RF.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (xif_issue_accept_i && xif_issue_we_i && (xif_issue_rd_i != 5'd0)) begin
      set_vec[xif_issue_rd_i] = 1'b1;
    end
    if (fifo_grant) begin
      clr_vec[fifo_rd_q[rptr_q]] = 1'b1;
    end
    if (byp_grant) begin
      clr_vec[xif_result_rd_i] = 1'b1;
    end
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  assign xif_issue_hazard_o = pending_q[xif_issue_rd_i] & xif_issue_we_i &
                              (xif_issue_rd_i != 5'd0);

  always_comb begin
    sb_stall_o = 1'b0;
    for (int unsigned i = 0; i < REGFILE_NUM_READ_PORTS; i++) begin
      if (rf_re_id_i[i] && (rf_raddr_id_i[i] != 5'd0) && pending_q[rf_raddr_id_i[i]]) begin
        sb_stall_o = 1'b1;
      end
    end
  end

  always_comb begin
    rf_we_d    = wb_grant | fifo_grant | byp_grant;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_grant) begin
      rf_waddr_d = wb_rf_waddr_i;
      rf_wdata_d = wb_rf_wdata_i;
    end else if (fifo_grant) begin
      rf_waddr_d = fifo_rd_q[rptr_q];
      rf_wdata_d = fifo_data_q[rptr_q];
    end else if (byp_grant) begin
      rf_waddr_d = xif_result_rd_i;
      rf_wdata_d = xif_result_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      pending_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      pending_q  <= pending_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // FIFO storage carries data only; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wptr_q]   <= xif_result_rd_i;
      fifo_data_q[wptr_q] <= xif_result_data_i;
    end
  end

  // A writing result for a register that was never issued is a protocol error.
  always_ff @(posedge clk) begin
    if (rst_n && res_write) begin
      assert (pending_q[xif_result_rd_i])
        else $error("xif result for non-pending rd x%0d", xif_result_rd_i);
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

endmodule

// File: tb/tb_cv32e40x_rf_wb_arbiter.sv
module tb_cv32e40x_rf_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int NRP   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic wb_valid, wb_we;
  logic [4:0] wb_addr;
  logic [31:0] wb_data;
  logic hold_o;
  logic iss_acc, iss_we;
  logic [4:0] iss_rd;
  logic haz_o;
  logic res_valid, ready_o, res_we;
  logic [4:0] res_rd;
  logic [31:0] res_data;
  logic [NRP-1:0] re;
  logic [NRP-1:0][4:0] raddr;
  logic stall_o;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;

  cv32e40x_rf_wb_arbiter #(
    .RESULT_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .REGFILE_NUM_READ_PORTS(NRP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid_i(wb_valid), .wb_rf_we_i(wb_we), .wb_rf_waddr_i(wb_addr),
    .wb_rf_wdata_i(wb_data), .wb_hold_o(hold_o),
    .xif_issue_accept_i(iss_acc), .xif_issue_we_i(iss_we), .xif_issue_rd_i(iss_rd),
    .xif_issue_hazard_o(haz_o),
    .xif_result_valid_i(res_valid), .xif_result_ready_o(ready_o),
    .xif_result_we_i(res_we), .xif_result_rd_i(res_rd), .xif_result_data_i(res_data),
    .rf_re_id_i(re), .rf_raddr_id_i(raddr), .sb_stall_o(stall_o),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata)
  );

  // Reference model: result queue, pending set, blocked-cycle count.
  typedef struct { logic [4:0] rd; logic [31:0] d; } item_t;
  item_t      fifo[$];
  bit [31:0]  pend;
  int         starve;
  logic [4:0] outstanding[$];
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fifo.delete();
    outstanding.delete();
    pend = '0;
    starve = 0;
    exp_we = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  task automatic idle();
    rst_n = 1'b1;
    wb_valid = 0; wb_we = 0; wb_addr = '0; wb_data = '0;
    iss_acc = 0; iss_we = 0; iss_rd = '0;
    res_valid = 0; res_we = 0; res_rd = '0; res_data = '0;
    re = '0; raddr = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check RF port.
  task automatic cyc();
    bit m_hold, m_ready, m_stall, m_haz, wbw, fg, wr, byp;
    int sz;
    #1;
    if (!rst_n) begin
      chk("ready_in_reset", ready_o, 1'b0);
      @(posedge clk); #1;
      model_reset();
      chk("rst_rf_we", rf_we, 1'b0);
      chk("rst_rf_waddr", rf_waddr, 5'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
    end else begin
      sz = fifo.size();
      m_hold  = (starve == LIMIT);
      m_ready = (sz < DEPTH);
      m_stall = 0;
      for (int i = 0; i < NRP; i++)
        if (re[i] && raddr[i] != 0 && pend[raddr[i]]) m_stall = 1;
      m_haz = pend[iss_rd] && iss_we && iss_rd != 0;
      chk("wb_hold", hold_o, m_hold);
      chk("res_ready", ready_o, m_ready);
      chk("sb_stall", stall_o, m_stall);
      chk("issue_hazard", haz_o, m_haz);

      wbw = wb_valid && wb_we && !m_hold;
      fg  = !wbw && sz > 0;
      wr  = res_valid && m_ready && res_we && res_rd != 0;
      byp = 0;
`ifdef CV32E40X_XIF_RESULT_BYPASS_EN
      byp = wr && sz == 0 && !wbw;
`endif
      exp_we = wbw || fg || byp;
      if (wbw) begin
        exp_addr = wb_addr; exp_data = wb_data;
      end else if (fg) begin
        exp_addr = fifo[0].rd; exp_data = fifo[0].d;
      end else if (byp) begin
        exp_addr = res_rd; exp_data = res_data;
      end
      if (fg) begin
        pend[fifo[0].rd] = 0;
        void'(fifo.pop_front());
      end
      if (byp) pend[res_rd] = 0;
      if (wr && !byp) fifo.push_back('{rd: res_rd, d: res_data});
      if (wr) begin
        for (int i = 0; i < outstanding.size(); i++)
          if (outstanding[i] == res_rd) begin
            outstanding.delete(i);
            break;
          end
      end
      if (iss_acc && iss_we && iss_rd != 0) begin
        pend[iss_rd] = 1;
        outstanding.push_back(iss_rd);
      end
      starve = (sz == 0 || fg) ? 0 : starve + 1;

      @(posedge clk); #1;
      chk("rf_we", rf_we, exp_we);
      chk("rf_waddr", rf_waddr, exp_addr);
      chk("rf_wdata", rf_wdata, exp_data);
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();

    // Reset with a result offered: nothing may be accepted.
    rst_n = 0; res_valid = 1; res_we = 1; res_rd = 5'd9; res_data = 32'hAAAA5555;
    iss_we = 1; iss_rd = 5'd5; re = 2'b01; raddr[0] = 5'd5;
    cyc();
    #1;
    chk("rst_hold", hold_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_hazard", haz_o, 1'b0);
    chk("rst_ready", ready_o, 1'b0);
    cyc();
    idle();
    #1 chk("ready_after_release", ready_o, 1'b1);
    cyc();
    chk("no_enqueue_in_reset", rf_we, 1'b0);

    // RAW stall on x5, then its result reaches the RF.
    iss_acc = 1; iss_we = 1; iss_rd = 5'd5;
    cyc();
    idle(); re = 2'b01; raddr[0] = 5'd5;
    #1 chk("raw_stall_x5", stall_o, 1'b1);
    cyc();
    res_valid = 1; res_we = 1; res_rd = 5'd5; res_data = 32'hDEADBEEF;
    cyc();
`ifdef CV32E40X_XIF_RESULT_BYPASS_EN
    chk("byp_x5_we", rf_we, 1'b1);
`else
    chk("x5_not_yet", rf_we, 1'b0);
    res_valid = 0;
    cyc();
`endif
    chk("x5_we", rf_we, 1'b1);
    chk("x5_addr", rf_waddr, 5'd5);
    chk("x5_data", rf_wdata, 32'hDEADBEEF);
    res_valid = 0;
    #1 chk("x5_stall_clear", stall_o, 1'b0);
    cyc();

    // Starvation: WB writes every cycle while x6 sits in the FIFO.
    idle(); iss_acc = 1; iss_we = 1; iss_rd = 5'd6;
    cyc();
    idle();
    wb_valid = 1; wb_we = 1; wb_addr = 5'd10; wb_data = 32'h0000_1010;
    res_valid = 1; res_we = 1; res_rd = 5'd6; res_data = 32'h66;
    cyc();
    res_valid = 0;
    for (int i = 0; i < 5; i++) begin
      wb_data = $urandom;
      #1 chk("starve_hold", hold_o, (i == 4));
      cyc();
    end
    chk("starve_we", rf_we, 1'b1);
    chk("starve_addr", rf_waddr, 5'd6);
    chk("starve_data", rf_wdata, 32'h66);
    idle();
    cyc();

    // WAW hazard on x7; x0 never raises a hazard or pends.
    iss_acc = 1; iss_we = 1; iss_rd = 5'd7;
    cyc();
    iss_acc = 0;
    #1 chk("waw_x7", haz_o, 1'b1);
    cyc();
    iss_acc = 1; iss_rd = 5'd0;
    #1 chk("issue_x0_no_hazard", haz_o, 1'b0);
    cyc();
    idle(); res_valid = 1; res_we = 1; res_rd = 5'd7; res_data = 32'h7777;
    cyc();
    idle(); cyc(); cyc();

    // Fill, drain and wrap the FIFO with five results x11..x15.
    for (int r = 11; r <= 15; r++) begin
      idle(); iss_acc = 1; iss_we = 1; iss_rd = 5'(r);
      cyc();
    end
    idle(); wb_valid = 1; wb_we = 1; wb_addr = 5'd20; wb_data = 32'h2020;
    res_valid = 1; res_we = 1; res_rd = 5'd11; res_data = 32'h1111;
    cyc();
    res_rd = 5'd12; res_data = 32'h1212;
    cyc();
    res_valid = 0;
    #1 chk("fifo_full_ready", ready_o, 1'b0);
    cyc();
    wb_valid = 0;
    #1 chk("full_no_passthru", ready_o, 1'b0);
    cyc();
    for (int r = 13; r <= 15; r++) begin
      res_valid = 1; res_we = 1; res_rd = 5'(r); res_data = 32'h100 + r;
      #1 chk("push_pop_ready", ready_o, 1'b1);
      cyc();
    end
    idle(); cyc(); cyc(); cyc();

`ifdef CV32E40X_XIF_RESULT_BYPASS_EN
    // Bypass on an idle port, and enqueue when WB competes.
    iss_acc = 1; iss_we = 1; iss_rd = 5'd3;
    cyc();
    idle(); res_valid = 1; res_we = 1; res_rd = 5'd3; res_data = 32'h1234;
    cyc();
    chk("byp_x3_we", rf_we, 1'b1);
    chk("byp_x3_addr", rf_waddr, 5'd3);
    chk("byp_x3_data", rf_wdata, 32'h1234);
    idle(); iss_acc = 1; iss_we = 1; iss_rd = 5'd4;
    cyc();
    idle(); wb_valid = 1; wb_we = 1; wb_addr = 5'd21; wb_data = 32'h2121;
    res_valid = 1; res_we = 1; res_rd = 5'd4; res_data = 32'h4444;
    cyc();
    chk("byp_wb_wins", rf_waddr, 5'd21);
    idle();
    cyc();
    chk("byp_enq_addr", rf_waddr, 5'd4);
    chk("byp_enq_data", rf_wdata, 32'h4444);
`endif

    // Randomized traffic, including occasional mid-run resets.
    for (int n = 0; n < 600; n++) begin
      int idx;
      rst_n    = ($urandom_range(0, 79) != 0);
      wb_valid = ($urandom_range(0, 2) != 0);
      wb_we    = ($urandom_range(0, 3) != 0);
      wb_addr  = 5'($urandom);
      wb_data  = $urandom;
      iss_rd   = 5'($urandom);
      iss_we   = ($urandom_range(0, 3) != 0);
      iss_acc  = ($urandom_range(0, 2) == 0) && !(pend[iss_rd] && iss_we && iss_rd != 0);
      if (outstanding.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, outstanding.size() - 1);
        res_valid = 1; res_we = 1; res_rd = outstanding[idx];
      end else begin
        res_valid = ($urandom_range(0, 3) == 0);
        res_we    = $urandom_range(0, 1);
        res_rd    = res_we ? 5'd0 : 5'($urandom);
      end
      res_data = $urandom;
      re       = NRP'($urandom);
      raddr    = (NRP * 5)'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
